// File: rtl/c_buft_bus_arbiter.sv
// Round-robin arbiter driving the active-low T enables of a group of BUFT slices
// that share one bus, with a break-before-make all-Z gap on every hand-over.
module c_buft_bus_arbiter #(
    parameter int C_NUM_SRC   = 4,
    parameter int C_GAP       = 1,
    parameter int C_MAX_HOLD  = 0,
    parameter int C_SEL_WIDTH = 2
) (
    input  logic                   CLK,
    input  logic                   SCLR,
    input  logic                   CE,
    input  logic [C_NUM_SRC-1:0]   REQ,
    output logic [C_NUM_SRC-1:0]   T,
    output logic [C_NUM_SRC-1:0]   GNT,
    output logic [C_SEL_WIDTH-1:0] OWNER,
    output logic                   BUS_ACTIVE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int GW = $clog2(C_GAP + 1);
    localparam int HW = (C_MAX_HOLD > 0) ? $clog2(C_MAX_HOLD + 1) : 1;

    localparam logic [GW-1:0]          GAP_LAST   = GW'(C_GAP);
    localparam logic [HW-1:0]          HOLD_MAX   = HW'(C_MAX_HOLD);
    localparam logic [HW-1:0]          HOLD_START = (C_MAX_HOLD > 0) ? HW'(1) : '0;
    localparam logic [C_SEL_WIDTH-1:0] LAST_RST   = C_SEL_WIDTH'(C_NUM_SRC - 1);

    logic [1:0]             state_q, state_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [C_SEL_WIDTH-1:0] last_q, last_d;
    logic [C_SEL_WIDTH-1:0] owner_q, owner_d;
    logic [C_NUM_SRC-1:0]   t_q, t_d;

    logic                   pick_valid;
    logic [C_SEL_WIDTH-1:0] pick_idx;
    logic                   owner_req;
    logic                   other_req;

    // Scan downward so the closest set bit after last_q is the final assignment.
    always_comb begin
        int                     idx;
        logic [C_SEL_WIDTH-1:0] idx_s;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_s      = '0;
        for (int i = C_NUM_SRC; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= C_NUM_SRC) begin
                idx = idx - C_NUM_SRC;
            end
            idx_s = C_SEL_WIDTH'(idx);
            if (REQ[idx_s]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_s;
            end
        end
    end

    // While owning, t_q has a single 0 at the owner, so it doubles as a mask.
    assign owner_req = |(REQ & ~t_q);
    assign other_req = |(REQ & t_q);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        last_d  = last_q;
        owner_d = owner_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d           = S_OWN;
                    t_d               = '1;
                    t_d[pick_idx]     = 1'b0;
                    owner_d           = pick_idx;
                    last_d            = pick_idx;
                    hold_d            = HOLD_START;
                    gap_d             = '0;
                end
            end
            S_OWN: begin
                if (!owner_req ||
                    ((C_MAX_HOLD > 0) && (hold_q == HOLD_MAX) && other_req)) begin
                    state_d = S_GAP;
                    t_d     = '1;
                    gap_d   = GW'(1);
                    hold_d  = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (pick_valid) begin
                        state_d       = S_OWN;
                        t_d           = '1;
                        t_d[pick_idx] = 1'b0;
                        owner_d       = pick_idx;
                        last_d        = pick_idx;
                        hold_d        = HOLD_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '1;
                gap_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            hold_q  <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
            t_q     <= '1;
        end else if (CE) begin
            state_q <= state_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            t_q     <= t_d;
        end
    end

    generate
        for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_gnt
            assign GNT[gi] = ~t_q[gi];
        end
    endgenerate

    assign T          = t_q;
    assign OWNER      = owner_q;
    assign BUS_ACTIVE = ~&t_q;

endmodule

// File: tb/tb_c_buft_bus_arbiter.sv
// Directed bench for c_buft_bus_arbiter: three instances cover the default
// configuration, a 3-cycle gap, and a 4-cycle hold limit.
module tb_c_buft_bus_arbiter;

    logic       clk;
    logic       sclr;
    logic       ce;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] t_a, t_b, t_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       ba_a, ba_b, ba_c;

    int total;
    int bad;

    c_buft_bus_arbiter #(.C_NUM_SRC(4), .C_GAP(1), .C_MAX_HOLD(0), .C_SEL_WIDTH(2)) u_dut (
        .CLK(clk), .SCLR(sclr), .CE(ce), .REQ(req_a),
        .T(t_a), .GNT(gnt_a), .OWNER(owner_a), .BUS_ACTIVE(ba_a)
    );

    c_buft_bus_arbiter #(.C_NUM_SRC(4), .C_GAP(3), .C_MAX_HOLD(0), .C_SEL_WIDTH(2)) u_gap (
        .CLK(clk), .SCLR(sclr), .CE(ce), .REQ(req_b),
        .T(t_b), .GNT(gnt_b), .OWNER(owner_b), .BUS_ACTIVE(ba_b)
    );

    c_buft_bus_arbiter #(.C_NUM_SRC(4), .C_GAP(1), .C_MAX_HOLD(4), .C_SEL_WIDTH(2)) u_hold (
        .CLK(clk), .SCLR(sclr), .CE(ce), .REQ(req_c),
        .T(t_c), .GNT(gnt_c), .OWNER(owner_c), .BUS_ACTIVE(ba_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {T, GNT, OWNER, BUS_ACTIVE} for a given expected T and owner.
    function automatic logic [10:0] exp_vec(input logic [3:0] t, input logic [1:0] own);
        return {t, ~t, own, ~&t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sclr  = 1'b1;
        ce    = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        tick();
        tick();
        sclr = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        do_reset();
        e = exp_vec(4'b1111, 2'd0);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("reset_state ok %b", e);
        // Single request: one edge to drive.
        req_a = 4'b0100;
        total++;
        if (t_a !== 4'b1111) begin
            bad++;
            $display("FAIL pre_grant_t got=%b want=1111", t_a);
        end else $display("pre_grant_t ok");
        tick();
        e = exp_vec(4'b1011, 2'd2);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL single_grant got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("single_grant ok %b", e);
    endtask

    task automatic test_release_idle();
        logic [10:0] e;
        req_a = 4'b0000;
        tick();
        e = exp_vec(4'b1111, 2'd2);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL release_gap got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("release_gap ok %b", e);
        tick();
        tick();
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL release_idle got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("release_idle ok %b", e);
    endtask

    task automatic test_round_robin();
        logic [10:0] e;
        logic [3:0]  tn;
        logic [1:0]  own;
        do_reset();
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            own = 2'(k % 4);
            tn  = 4'b1111;
            tn[own] = 1'b0;
            e = exp_vec(tn, own);
            for (int c = 0; c < 3; c++) begin
                if (c > 0) tick();
                else if (k == 0) tick();
                total++;
                if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
                    bad++;
                    $display("FAIL rr_own k=%0d c=%0d got=%b want=%b", k, c,
                             {t_a, gnt_a, owner_a, ba_a}, e);
                end else $display("rr_own k=%0d c=%0d ok %b", k, c, e);
            end
            if (k == 4) break;
            req_a[own] = 1'b0;
            tick();
            e = exp_vec(4'b1111, own);
            total++;
            if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
                bad++;
                $display("FAIL rr_gap k=%0d got=%b want=%b", k, {t_a, gnt_a, owner_a, ba_a}, e);
            end else $display("rr_gap k=%0d ok", k);
            req_a = 4'b1111;
            tick();
        end
        req_a = '0;
    endtask

    task automatic test_gap_length();
        logic [10:0] e;
        do_reset();
        req_b = 4'b0010;
        tick();
        e = exp_vec(4'b1101, 2'd1);
        total++;
        if ({t_b, gnt_b, owner_b, ba_b} !== e) begin
            bad++;
            $display("FAIL gap3_grant got=%b want=%b", {t_b, gnt_b, owner_b, ba_b}, e);
        end else $display("gap3_grant ok %b", e);
        req_b = 4'b1000;
        e = exp_vec(4'b1111, 2'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({t_b, gnt_b, owner_b, ba_b} !== e) begin
                bad++;
                $display("FAIL gap3_z c=%0d got=%b want=%b", c, {t_b, gnt_b, owner_b, ba_b}, e);
            end else $display("gap3_z c=%0d ok", c);
        end
        tick();
        e = exp_vec(4'b0111, 2'd3);
        total++;
        if ({t_b, gnt_b, owner_b, ba_b} !== e) begin
            bad++;
            $display("FAIL gap3_next got=%b want=%b", {t_b, gnt_b, owner_b, ba_b}, e);
        end else $display("gap3_next ok %b", e);
        req_b = '0;
    endtask

    task automatic test_forced_release();
        logic [10:0] e;
        do_reset();
        req_c = 4'b0001;
        tick();
        req_c = 4'b0101;
        e = exp_vec(4'b1110, 2'd0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            total++;
            if ({t_c, gnt_c, owner_c, ba_c} !== e) begin
                bad++;
                $display("FAIL hold_own c=%0d got=%b want=%b", c, {t_c, gnt_c, owner_c, ba_c}, e);
            end else $display("hold_own c=%0d ok", c);
        end
        tick();
        e = exp_vec(4'b1111, 2'd0);
        total++;
        if ({t_c, gnt_c, owner_c, ba_c} !== e) begin
            bad++;
            $display("FAIL hold_gap got=%b want=%b", {t_c, gnt_c, owner_c, ba_c}, e);
        end else $display("hold_gap ok");
        tick();
        e = exp_vec(4'b1011, 2'd2);
        total++;
        if ({t_c, gnt_c, owner_c, ba_c} !== e) begin
            bad++;
            $display("FAIL hold_next got=%b want=%b", {t_c, gnt_c, owner_c, ba_c}, e);
        end else $display("hold_next ok %b", e);
        // Alone on the bus, source 0 keeps it well past the hold limit.
        do_reset();
        req_c = 4'b0001;
        e = exp_vec(4'b1110, 2'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({t_c, gnt_c, owner_c, ba_c} !== e) begin
                bad++;
                $display("FAIL hold_alone c=%0d got=%b want=%b", c, {t_c, gnt_c, owner_c, ba_c}, e);
            end else $display("hold_alone c=%0d ok", c);
        end
        req_c = '0;
    endtask

    task automatic test_ce_sclr();
        logic [10:0] e;
        do_reset();
        req_a = 4'b0001;
        tick();
        req_a = 4'b0010;
        tick();
        ce = 1'b0;
        e = exp_vec(4'b1111, 2'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
                bad++;
                $display("FAIL ce_freeze c=%0d got=%b want=%b", c, {t_a, gnt_a, owner_a, ba_a}, e);
            end else $display("ce_freeze c=%0d ok", c);
        end
        ce = 1'b1;
        tick();
        e = exp_vec(4'b1101, 2'd1);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL ce_resume got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("ce_resume ok %b", e);
        req_a = 4'b1000;
        tick();
        tick();
        e = exp_vec(4'b0111, 2'd3);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL own3 got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("own3 ok %b", e);
        ce   = 1'b0;
        sclr = 1'b1;
        tick();
        e = exp_vec(4'b1111, 2'd0);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL sclr_over_ce got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("sclr_over_ce ok %b", e);
        sclr  = 1'b0;
        ce    = 1'b1;
        req_a = 4'b1001;
        tick();
        e = exp_vec(4'b1110, 2'd0);
        total++;
        if ({t_a, gnt_a, owner_a, ba_a} !== e) begin
            bad++;
            $display("FAIL post_sclr_pick got=%b want=%b", {t_a, gnt_a, owner_a, ba_a}, e);
        end else $display("post_sclr_pick ok %b", e);
        req_a = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sclr  = 1'b1;
        ce    = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        test_reset();
        test_release_idle();
        test_round_robin();
        test_gap_length();
        test_forced_release();
        test_ce_sclr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
